// File: rtl/pulse_capture.sv
// Arm-triggered pulse measurement: reports arm-to-pulse delay and pulse width in
// sys_clk cycles, with glitch rejection and a timeout on both phases.
module pulse_capture #(
    parameter int               CNT_W     = 25,
    parameter logic [CNT_W-1:0] TIMEOUT   = 25'd999_999,
    parameter logic [CNT_W-1:0] MIN_WIDTH = 25'd2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             arm_flag,
    input  logic             pulse_in,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_delay,
    output logic [CNT_W-1:0] meas_width,
    output logic             meas_timeout
);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Index 0 = arm_flag, index 1 = pulse_in; identical depth keeps their timing aligned.
    logic [1:0] async_in;
    logic [2:0] sync_reg [2];

    assign async_in = {pulse_in, arm_flag};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    sync_reg[gi] <= '0;
                end else begin
                    sync_reg[gi] <= {sync_reg[gi][1:0], async_in[gi]};
                end
            end
        end
    endgenerate

    logic arm_rise, p_rise, p_fall, p_high;

    assign arm_rise = sync_reg[0][1] & ~sync_reg[0][2];
    assign p_high   = sync_reg[1][1];
    assign p_rise   = sync_reg[1][1] & ~sync_reg[1][2];
    assign p_fall   = ~sync_reg[1][1] & sync_reg[1][2];

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] dcnt_reg, dcnt_next;
    logic [CNT_W-1:0] wcnt_reg, wcnt_next;
    logic [CNT_W-1:0] delay_reg, delay_next;
    logic             load_result;
    logic [CNT_W-1:0] res_delay, res_width;
    logic             res_timeout;

    always_comb begin
        state_next  = state_reg;
        dcnt_next   = dcnt_reg;
        wcnt_next   = wcnt_reg;
        delay_next  = delay_reg;
        load_result = 1'b0;
        res_delay   = '0;
        res_width   = '0;
        res_timeout = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arm_rise) begin
                    if (p_rise) begin
                        state_next = HIGH;
                        delay_next = '0;
                        wcnt_next  = ONE;
                    end else begin
                        state_next = WAIT_RISE;
                        dcnt_next  = ONE;
                    end
                end
            end
            WAIT_RISE: begin
                if (p_rise) begin
                    state_next = HIGH;
                    delay_next = dcnt_reg;
                    wcnt_next  = ONE;
                end else if (dcnt_reg >= TIMEOUT) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                    res_delay   = TIMEOUT;
                    res_timeout = 1'b1;
                end else begin
                    dcnt_next = dcnt_reg + ONE;
                end
            end
            HIGH: begin
                if (p_fall) begin
                    if (wcnt_reg >= MIN_WIDTH) begin
                        state_next  = DONE;
                        load_result = 1'b1;
                        res_delay   = delay_reg;
                        res_width   = wcnt_reg;
                    end else begin
                        // Glitch: resume the delay count as if the glitch never happened.
                        state_next = WAIT_RISE;
                        dcnt_next  = delay_reg + wcnt_reg + ONE;
                    end
                end else if (wcnt_reg >= TIMEOUT) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                    res_delay   = delay_reg;
                    res_width   = TIMEOUT;
                    res_timeout = 1'b1;
                end else if (p_high) begin
                    wcnt_next = wcnt_reg + ONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg    <= IDLE;
            dcnt_reg     <= '0;
            wcnt_reg     <= '0;
            delay_reg    <= '0;
            meas_valid   <= 1'b0;
            meas_delay   <= '0;
            meas_width   <= '0;
            meas_timeout <= 1'b0;
        end else begin
            state_reg  <= state_next;
            dcnt_reg   <= dcnt_next;
            wcnt_reg   <= wcnt_next;
            delay_reg  <= delay_next;
            meas_valid <= load_result;
            if (load_result) begin
                meas_delay   <= res_delay;
                meas_width   <= res_width;
                meas_timeout <= res_timeout;
            end
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_pulse_capture.sv
// Scoreboard bench for pulse_capture: directed arm/pulse scenarios with
// hand-computed results, checked by an independent monitor on meas_valid.
module tb_pulse_capture;

    localparam int               CNT_W = 25;
    localparam logic [CNT_W-1:0] TO    = 25'd50;
    localparam logic [CNT_W-1:0] MINW  = 25'd2;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             arm_flag = 1'b0;
    logic             pulse_in = 1'b0;
    logic             busy;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_delay;
    logic [CNT_W-1:0] meas_width;
    logic             meas_timeout;

    pulse_capture #(.CNT_W(CNT_W), .TIMEOUT(TO), .MIN_WIDTH(MINW)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .arm_flag    (arm_flag),
        .pulse_in    (pulse_in),
        .busy        (busy),
        .meas_valid  (meas_valid),
        .meas_delay  (meas_delay),
        .meas_width  (meas_width),
        .meas_timeout(meas_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [CNT_W-1:0] delay;
        logic [CNT_W-1:0] width;
        logic             timeout;
    } result_t;

    result_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest pending expectation.
    initial begin
        result_t e;
        logic    prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (prev_valid) chk("busy_after_valid", 32'(busy), 32'd0);
            prev_valid = 1'b0;
            if (!sys_rst && meas_valid === 1'b1) begin
                prev_valid = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(meas_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("delay", 32'(meas_delay), 32'(e.delay));
                    chk("width", 32'(meas_width), 32'(e.width));
                    chk("timeout", 32'(meas_timeout), 32'(e.timeout));
                    $display("result delay=%0d width=%0d timeout=%0d", meas_delay, meas_width, meas_timeout);
                end
            end
        end
    end

    // One capture: arm rises at cycle 0 (optional second rise at arm2), optional
    // 1-cycle glitch, main pulse [p_at, p_at+p_w), optional pre-high until pre_end.
    task automatic run_case(input int arm2, input int glitch, input int p_at, input int p_w,
                            input int pre_end, input int total, input result_t exp);
        exp_q.push_back(exp);
        if (pre_end > 0) begin
            @(negedge sys_clk);
            pulse_in = 1'b1;
            repeat (4) @(negedge sys_clk);
        end
        for (int c = 0; c < total; c++) begin
            @(negedge sys_clk);
            arm_flag = (c < 2) || (arm2 >= 0 && c >= arm2 && c < arm2 + 2);
            pulse_in = (c < pre_end) || (glitch >= 0 && c == glitch) ||
                       (p_w > 0 && c >= p_at && c < p_at + p_w);
        end
        @(negedge sys_clk);
        arm_flag = 1'b0;
        pulse_in = 1'b0;
        repeat (6) @(negedge sys_clk);
    endtask

    initial begin
        int waited;
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(meas_valid), 32'd0);
        chk("rst_delay", 32'(meas_delay), 32'd0);
        chk("rst_width", 32'(meas_width), 32'd0);
        chk("rst_timeout", 32'(meas_timeout), 32'd0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        run_case(-1, -1, 10, 5, 0, 25, '{delay: 25'd10, width: 25'd5, timeout: 1'b0});
        run_case(-1, -1, 0, 3, 0, 15, '{delay: 25'd0, width: 25'd3, timeout: 1'b0});
        run_case(-1, 4, 20, 6, 0, 36, '{delay: 25'd20, width: 25'd6, timeout: 1'b0});
        run_case(-1, -1, 0, 0, 0, 70, '{delay: 25'd50, width: 25'd0, timeout: 1'b1});
        run_case(3, -1, 8, 4, 0, 22, '{delay: 25'd8, width: 25'd4, timeout: 1'b0});
        run_case(-1, -1, 10, 4, 3, 24, '{delay: 25'd10, width: 25'd4, timeout: 1'b0});
        run_case(-1, -1, 5, 2, 0, 17, '{delay: 25'd5, width: 25'd2, timeout: 1'b0});
        run_case(-1, -1, 7, 60, 0, 75, '{delay: 25'd7, width: 25'd50, timeout: 1'b1});

        // Reset while the pulse is high: no strobe, outputs cleared.
        @(negedge sys_clk);
        arm_flag = 1'b1;
        pulse_in = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("busy_in_high", 32'(busy), 32'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(meas_valid), 32'd0);
        chk("midrst_delay", 32'(meas_delay), 32'd0);
        chk("midrst_width", 32'(meas_width), 32'd0);
        chk("midrst_timeout", 32'(meas_timeout), 32'd0);
        sys_rst  = 1'b0;
        arm_flag = 1'b0;
        pulse_in = 1'b0;
        repeat (6) @(negedge sys_clk);
        run_case(-1, -1, 12, 7, 0, 28, '{delay: 25'd12, width: 25'd7, timeout: 1'b0});

        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge sys_clk);
            waited++;
        end
        chk("pending_results", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
